// File: rtl/serial_pkg.sv
// Shared types and default constants for the serial receive/transmit blocks.
package serial_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam int unsigned SERIAL_DATA_W       = 8;
  localparam int unsigned SERIAL_CLKS_PER_BIT = 16;

endpackage

// File: rtl/bit_timer.sv
// Free-running bit-period cycle counter with mid-bit and end-of-bit ticks.
module bit_timer
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = SERIAL_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic half_tick,
  output logic full_tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HalfCount = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LastCount = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  // Wrap explicitly so non-power-of-two periods keep exact timing.
  always_comb begin
    count_d = count_q + CW'(1);
    if (clear || (count_q == LastCount)) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign half_tick = (count_q == HalfCount);
  assign full_tick = (count_q == LastCount);

endmodule

// File: rtl/serial_rx.sv
// Start/data/stop serial frame receiver with a valid/ready word output.
module serial_rx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W       = SERIAL_DATA_W,
  parameter int unsigned CLKS_PER_BIT = SERIAL_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              frame_err_o,
  output logic              overrun_o
);

  localparam int unsigned BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LastBit = BW'(DATA_W - 1);

  rx_state_t         state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  logic timer_clear;
  logic half_tick;
  logic full_tick;
  logic stop_ok;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  // Frame sequencing. The timer is held cleared while waiting so the start
  // edge always begins counting from zero.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    timer_clear = 1'b0;
    stop_ok     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        timer_clear = 1'b1;
        bit_cnt_d   = '0;
        if (!rxd) begin
          state_d = START;
        end
      end
      START: begin
        if (half_tick) begin
          timer_clear = 1'b1;
          state_d     = rxd ? IDLE : DATA;
        end
      end
      DATA: begin
        if (full_tick) begin
          shift_d   = DATA_W'({rxd, shift_q} >> 1);
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LastBit) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (full_tick) begin
          if (rxd) begin
            stop_ok = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        timer_clear = 1'b1;
        if (rxd) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output holding register; a completed word never waits for the consumer.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (stop_ok) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: directed vector table, corner sequences, random vs model.
module tb_serial_rx;

  localparam int W       = 8;
  localparam int C       = 16;
  localparam int STOP_N  = C / 2 + (W + 1) * C;
  localparam int NR      = 8000;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         rxd     = 1'b1;
  logic         ready_i = 1'b0;
  logic [W-1:0] data_o;
  logic         valid_o;
  logic         frame_err_o;
  logic         overrun_o;

  int total = 0;
  int bad   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  serial_rx #(
    .DATA_W      (W),
    .CLKS_PER_BIT(C)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err_o === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (overrun_o === 1'b1) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    ready_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame from a negedge; iteration n sets the line seen at edge t0+n.
  task automatic send_frame(input logic [W-1:0] d, input logic stop, input logic rdy,
                            input int stop_len, input int low_after,
                            output logic pv, output logic v, output logic [W-1:0] dq,
                            output logic fe, output logic ov);
    int body;
    int len;
    body = (W + 1) * C + stop_len;
    len  = body + low_after;
    if (len < STOP_N + 2) len = STOP_N + 2;
    for (int n = 0; n < len; n++) begin
      if (n == STOP_N) pv = valid_o;
      if (n == STOP_N + 1) begin
        v  = valid_o;
        dq = data_o;
        fe = frame_err_o;
        ov = overrun_o;
      end
      if (n < C) rxd = 1'b0;
      else if (n < (W + 1) * C) rxd = d[(n - C) / C];
      else if (n < body) rxd = stop;
      else if (n < body + low_after) rxd = 1'b0;
      else rxd = 1'b1;
      ready_i = (n == STOP_N) ? rdy : 1'b0;
      @(negedge clk);
    end
    ready_i = 1'b0;
  endtask

  task automatic accept(input string name);
    logic [W-1:0] held;
    held = data_o;
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check({name, "_valid_clear"}, 32'(valid_o), 32'd0);
    check({name, "_data_hold"}, 32'(data_o), 32'(held));
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic         stop;
    logic         rdy;
    logic         acc;
    logic         exp_pv;
    logic         exp_v;
    logic [W-1:0] exp_d;
    logic         exp_fe;
    logic         exp_ov;
  } vec_t;

  vec_t vecs[7];

  bit           line[NR];
  bit           rdy_a[NR];
  bit           ev_del[NR];
  bit           ev_fe[NR];
  logic [W-1:0] ev_word[NR];
  bit           e_v[NR];
  bit           e_fe[NR];
  bit           e_ov[NR];
  logic [W-1:0] e_d[NR];

  logic         pv, v, fe, ov;
  logic [W-1:0] dq;
  int           f0, o0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'h12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};

    // Reset held with the line toggling.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd = ~rxd;
    end
    check("reset_outputs", {data_o, valid_o, frame_err_o, overrun_o}, 32'd0);
    rxd = 1'b1;
    rst_n = 1'b1;
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    idle(50);
    check("post_reset_outputs", {data_o, valid_o, frame_err_o, overrun_o}, 32'd0);
    check("post_reset_pulses", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'd0);

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].d, vecs[i].stop, vecs[i].rdy, C, 0, pv, v, dq, fe, ov);
      check($sformatf("vec%0d_pre_valid", i), 32'(pv), 32'(vecs[i].exp_pv));
      check($sformatf("vec%0d_valid", i), 32'(v), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d_data", i), 32'(dq), 32'(vecs[i].exp_d));
      check($sformatf("vec%0d_frame_err", i), 32'(fe), 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d_overrun", i), 32'(ov), 32'(vecs[i].exp_ov));
      if (vecs[i].acc) accept($sformatf("vec%0d_accept", i));
      idle(4);
    end

    // Short glitch must be rejected, then a real frame received.
    f0 = ferr_cnt;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    idle(30);
    check("glitch_no_valid", 32'(valid_o), 32'd0);
    check("glitch_no_err", 32'(ferr_cnt - f0), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0, C, 0, pv, v, dq, fe, ov);
    check("glitch_next_data", {v, dq}, {1'b1, 8'h3C});
    accept("glitch_accept");
    idle(3);

    // Framing error with the line held low afterwards: exactly one pulse.
    f0 = ferr_cnt;
    send_frame(8'hFF, 1'b0, 1'b0, C, 40, pv, v, dq, fe, ov);
    idle(5);
    check("break_err_at_stop", 32'(fe), 32'd1);
    check("break_err_count", 32'(ferr_cnt - f0), 32'd1);
    check("break_no_valid", 32'(valid_o), 32'd0);
    send_frame(8'h12, 1'b1, 1'b0, C, 0, pv, v, dq, fe, ov);
    check("break_next_data", {v, dq, fe}, {1'b1, 8'h12, 1'b0});
    accept("break_accept");
    idle(3);

    // Back-to-back frames, consumer stalled then ready at the second stop.
    send_frame(8'h11, 1'b1, 1'b0, C, 0, pv, v, dq, fe, ov);
    send_frame(8'h22, 1'b1, 1'b0, C, 0, pv, v, dq, fe, ov);
    check("b2b_overrun", {ov, v, dq}, {1'b1, 1'b1, 8'h11});
    accept("b2b_accept1");
    send_frame(8'h11, 1'b1, 1'b0, C, 0, pv, v, dq, fe, ov);
    send_frame(8'h22, 1'b1, 1'b1, C, 0, pv, v, dq, fe, ov);
    check("b2b_replace", {ov, v, dq}, {1'b0, 1'b1, 8'h22});
    accept("b2b_accept2");
    idle(3);

    // Reset in the middle of bit 4 of 0x5A.
    rxd = 1'b0;
    repeat (C) @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      rxd = b[0];
      repeat (C) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (C / 2) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midreset_outputs", {data_o, valid_o, frame_err_o, overrun_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    idle(30);
    check("midreset_no_valid", 32'(valid_o), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0, C, 0, pv, v, dq, fe, ov);
    idle(2);
    check("midreset_next", {pv, v, dq}, {1'b0, 1'b1, 8'h81});
    check("midreset_no_pulses", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'd0);

    // Random line and consumer activity against the frame-timing model.
    for (int k = 0; k < NR; k++) begin
      line[k]   = 1'b1;
      rdy_a[k]  = ($urandom_range(0, 3) == 0);
      ev_del[k] = 1'b0;
      ev_fe[k]  = 1'b0;
      ev_word[k] = '0;
    end
    begin
      int pos;
      pos = 5;
      while (pos < NR - 400) begin
        int kind;
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
          int l;
          l = $urandom_range(1, C / 2 - 1);
          for (int i = 0; i < l; i++) line[pos + i] = 1'b0;
          pos += l + $urandom_range(1, 20);
        end else begin
          logic [W-1:0] d;
          bit stopb;
          int slen;
          d = W'($urandom);
          stopb = (kind != 1);
          slen = $urandom_range(9, C);
          for (int i = 0; i < C; i++) line[pos + i] = 1'b0;
          for (int b = 0; b < W; b++)
            for (int i = 0; i < C; i++) line[pos + C + b * C + i] = d[b];
          for (int i = 0; i < slen; i++) line[pos + (W + 1) * C + i] = stopb;
          pos += (W + 1) * C + slen;
          if (!stopb) begin
            int la;
            la = $urandom_range(0, 60);
            for (int i = 0; i < la; i++) line[pos + i] = 1'b0;
            pos += la + 1;
          end
          if ($urandom_range(0, 2) != 0) pos += $urandom_range(0, 30);
        end
      end
    end

    // Model: locate frames by the sampling-instant arithmetic, then apply port rules.
    begin
      int t;
      bit mv;
      logic [W-1:0] md;
      t = 0;
      while (t < NR) begin
        if (!line[t]) begin
          int s;
          int p;
          s = t + C / 2;
          p = s + (W + 1) * C;
          if (p >= NR) break;
          if (line[s]) begin
            t = s + 1;
          end else if (line[p]) begin
            for (int i = 0; i < W; i++) ev_word[p][i] = line[s + (i + 1) * C];
            ev_del[p] = 1'b1;
            t = p + 1;
          end else begin
            int q;
            ev_fe[p] = 1'b1;
            q = p + 1;
            while (q < NR && !line[q]) q++;
            t = q + 1;
          end
        end else begin
          t++;
        end
      end
      mv = 1'b0;
      md = '0;
      for (int k = 0; k < NR; k++) begin
        e_ov[k] = 1'b0;
        e_fe[k] = ev_fe[k];
        if (ev_del[k]) begin
          if (!mv || rdy_a[k]) begin
            md = ev_word[k];
            mv = 1'b1;
          end else begin
            e_ov[k] = 1'b1;
          end
        end else if (mv && rdy_a[k]) begin
          mv = 1'b0;
        end
        e_v[k] = mv;
        e_d[k] = md;
      end
    end

    @(negedge clk);
    rst_n = 1'b0;
    rxd = 1'b1;
    ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rxd = line[0];
    ready_i = rdy_a[0];
    for (int k = 0; k < NR; k++) begin
      @(negedge clk);
      check($sformatf("rand_valid@%0d", k), 32'(valid_o), 32'(e_v[k]));
      check($sformatf("rand_data@%0d", k), 32'(data_o), 32'(e_d[k]));
      check($sformatf("rand_frame_err@%0d", k), 32'(frame_err_o), 32'(e_fe[k]));
      check($sformatf("rand_overrun@%0d", k), 32'(overrun_o), 32'(e_ov[k]));
      if (k + 1 < NR) begin
        rxd = line[k + 1];
        ready_i = rdy_a[k + 1];
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
